// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder
// Desc   : Data-memory responder for the core's load/store port. Accepts one
//          word request at a time, inserts wait states, returns one response.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int c_cntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cntW-1:0] c_cntLoad =
        c_cntW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [c_cntW-1:0]   r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_respErr;
    logic [DATA_W-1:0]   r_respRdata;
    logic [DATA_W-1:0]   r_mem [0:(2**ADDR_W)-1];

    logic                w_addrErr;
    logic                w_accept;
    logic                w_access;
    logic                w_loadCnt;
    logic                w_setErr;
    logic                w_accWe;
    logic [ADDR_W-1:0]   w_accIdx;
    logic [DATA_W-1:0]   w_accWdata;
    logic                w_memWe;

    // Upper bits must be zero: out-of-range addresses are rejected, never aliased.
    assign w_addrErr = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        w_loadCnt   = 1'b0;
        w_setErr    = 1'b0;
        w_accWe     = r_we;
        w_accIdx    = r_idx;
        w_accWdata  = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_addrErr) begin
                        w_setErr    = 1'b1;
                        w_stateNext = S_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        w_access    = 1'b1;
                        w_accWe     = req_we;
                        w_accIdx    = req_addr[ADDR_W+1:2];
                        w_accWdata  = req_wdata;
                        w_stateNext = S_RESP;
                    end else begin
                        w_loadCnt   = 1'b1;
                        w_stateNext = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_stateNext = S_RESP;
                end
            end
            S_RESP: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_respErr   <= 1'b0;
            r_respRdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_idx   <= req_addr[ADDR_W+1:2];
                r_wdata <= req_wdata;
            end
            if (w_loadCnt) begin
                r_cnt <= c_cntLoad;
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_setErr) begin
                r_respErr   <= 1'b1;
                r_respRdata <= '0;
            end else if (w_access) begin
                r_respErr   <= 1'b0;
                r_respRdata <= w_accWe ? '0 : r_mem[w_accIdx];
            end else if (r_state == S_RESP) begin
                r_respErr   <= 1'b0;
                r_respRdata <= '0;
            end
        end
    end

    // Gated by rst so a request presented while reset is held never writes.
    assign w_memWe = w_access && w_accWe && rst;

    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_accIdx] <= w_accWdata;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_respRdata;
    assign resp_err   = r_respErr;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_responder
// Desc   : Self-checking bench; instance 0 has two wait states, instance 1 none.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        reqValid   [2];
    logic        reqReady   [2];
    logic        reqWe      [2];
    logic [31:0] reqAddr    [2];
    logic [31:0] reqWdata   [2];
    logic        respValid  [2];
    logic [31:0] respRdata  [2];
    logic        respErr    [2];
    logic        busyO      [2];

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [2][256];
    bit          wr  [2][256];

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) u_dutW2 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .resp_valid(respValid[0]), .resp_rdata(respRdata[0]),
        .resp_err(respErr[0]), .busy(busyO[0])
    );

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_dutW0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .resp_valid(respValid[1]), .resp_rdata(respRdata[1]),
        .resp_err(respErr[1]), .busy(busyO[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int waitOf(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // One complete transaction; returns what the DUT produced.
    task automatic doReq(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output int busyN);
        int n = 0;
        @(negedge clk);
        while (!reqReady[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        reqValid[d] = 1'b1;
        reqWe[d]    = we;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        @(negedge clk);
        reqValid[d] = 1'b0;
        busyN = int'(busyO[d]);
        lat   = 0;
        while (!respValid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
            busyN += int'(busyO[d]);
        end
        rdata = respRdata[d];
        err   = respErr[d];
        @(negedge clk);
        chk("resp_valid one cycle", {31'd0, respValid[d]}, 32'd0);
        chk("idle after resp rdata", respRdata[d], 32'd0);
    endtask

    // Transaction whose expectations come from the reference model.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
        logic [31:0] rd;
        logic        er;
        int          lat, bn, idx;
        bit          expErr, known;
        logic [31:0] expRd;
        expErr = (addr[1:0] != 0) || (addr >= 32'h400);
        idx    = int'(addr[9:2]);
        known  = 1'b1;
        expRd  = 32'd0;
        if (!expErr && !we) begin
            known = wr[d][idx];
            expRd = mdl[d][idx];
        end
        doReq(d, we, addr, wdata, rd, er, lat, bn);
        chk("model err", {31'd0, er}, {31'd0, expErr});
        chk("model latency", lat, expErr ? 0 : waitOf(d));
        chk("model busy cycles", bn, (expErr ? 0 : waitOf(d)) + 1);
        if (known) chk("model rdata", rd, expRd);
        if (!expErr && we) begin
            mdl[d][idx] = wdata;
            wr[d][idx]  = 1'b1;
        end
    endtask

    typedef struct {
        int          d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expErr;
        logic [31:0] expRdata;
        int          expLat;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, bn, n;

        tbl[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 2};
        tbl[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 2};
        tbl[2]  = '{0, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0, 0};
        tbl[3]  = '{0, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 1'b0, 32'h0, 2};
        tbl[4]  = '{0, 1'b1, 32'h0000_0400, 32'h0000_FFFF, 1'b1, 32'h0, 0};
        tbl[5]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0001, 2};
        tbl[6]  = '{0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0, 2};
        tbl[7]  = '{0, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D, 2};
        tbl[8]  = '{1, 1'b1, 32'h0000_0008, 32'h1122_3344, 1'b0, 32'h0, 0};
        tbl[9]  = '{1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h1122_3344, 0};
        tbl[10] = '{1, 1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0, 0};
        tbl[11] = '{1, 1'b0, 32'h8000_0008, 32'h0,         1'b1, 32'h0, 0};
        tbl[12] = '{0, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 1'b0, 32'h0, 2};
        tbl[13] = '{0, 1'b1, 32'h0000_0030, 32'h3030_3030, 1'b0, 32'h0, 2};
        tbl[14] = '{0, 1'b1, 32'h0000_0034, 32'h3434_3434, 1'b0, 32'h0, 2};

        for (int d = 0; d < 2; d++) begin
            reqValid[d] = 1'b0; reqWe[d] = 1'b0; reqAddr[d] = '0; reqWdata[d] = '0;
            for (int i = 0; i < 256; i++) begin
                mdl[d][i] = '0;
                wr[d][i]  = 1'b0;
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset req_ready", {31'd0, reqReady[d]}, 32'd1);
            chk("reset busy", {31'd0, busyO[d]}, 32'd0);
            chk("reset resp_valid", {31'd0, respValid[d]}, 32'd0);
            chk("reset resp_err", {31'd0, respErr[d]}, 32'd0);
            chk("reset resp_rdata", respRdata[d], 32'd0);
        end
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            doReq(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er, lat, bn);
            chk("table err", {31'd0, er}, {31'd0, tbl[i].expErr});
            chk("table rdata", rd, tbl[i].expRdata);
            chk("table latency", lat, tbl[i].expLat);
            chk("table busy cycles", bn, tbl[i].expLat + 1);
            if (tbl[i].we && !tbl[i].expErr) begin
                mdl[tbl[i].d][tbl[i].addr[9:2]] = tbl[i].wdata;
                wr[tbl[i].d][tbl[i].addr[9:2]]  = 1'b1;
            end
        end

        // Requests presented while reset is held must not reach the RAM
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            reqValid[d] = 1'b1; reqWe[d] = 1'b1;
            reqAddr[d]  = (d == 0) ? 32'h10 : 32'h8;
            reqWdata[d] = 32'h0BAD_F00D;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("held reset req_ready", {31'd0, reqReady[d]}, 32'd1);
            chk("held reset busy", {31'd0, busyO[d]}, 32'd0);
            chk("held reset resp_valid", {31'd0, respValid[d]}, 32'd0);
            reqValid[d] = 1'b0;
        end
        rst = 1'b1;
        txn(0, 1'b0, 32'h10, 32'h0);
        txn(1, 1'b0, 32'h8, 32'h0);

        // Reset during WAIT aborts the pending store
        @(negedge clk);
        reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = 32'h20; reqWdata[0] = 32'h1234_5678;
        @(negedge clk);
        chk("abort in wait busy", {31'd0, busyO[0]}, 32'd1);
        rst = 1'b0;
        reqValid[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            n += int'(respValid[0]);
        end
        chk("abort no response", n, 0);
        txn(0, 1'b0, 32'h20, 32'h0);

        // req_valid held through WAIT/RESP: the second address waits for IDLE
        @(negedge clk);
        reqValid[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 32'h30;
        @(negedge clk);
        reqAddr[0] = 32'h34;
        n = 0;
        while (!respValid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold first latency", n, 2);
        chk("hold first rdata", respRdata[0], 32'h3030_3030);
        @(negedge clk);
        chk("hold idle ready", {31'd0, reqReady[0]}, 32'd1);
        @(negedge clk);
        reqValid[0] = 1'b0;
        chk("hold second accepted", {31'd0, busyO[0]}, 32'd1);
        n = 0;
        while (!respValid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold second latency", n, 2);
        chk("hold second rdata", respRdata[0], 32'h3434_3434);

        // Zero wait states: one request every two cycles
        @(negedge clk);
        reqValid[1] = 1'b1; reqWe[1] = 1'b0; reqAddr[1] = 32'h8;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("b2b resp_valid", {31'd0, respValid[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) chk("b2b rdata", respRdata[1], 32'h1122_3344);
        end
        reqValid[1] = 1'b0;
        @(negedge clk);
        chk("b2b drained", {31'd0, respValid[1]}, 32'd0);

        // Randomised traffic against the reference model
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                int          kind;
                logic [31:0] a;
                kind = int'($urandom_range(0, 9));
                a    = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
                if (kind == 0) a = a | 32'($urandom_range(1, 3));
                else if (kind == 1) a = $urandom | 32'h0000_0400;
                else if (kind == 2) a = 32'h0000_03FC;
                txn(d, 1'($urandom_range(0, 1)), a, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
